uart_rx_sampler: RTL

//  - Serial receive front end for a spare Fipsy pin (e.g. PIN7) driven by an external 8N1 UART.
//  - Clocked from the OSCH internal oscillator (2.08 MHz); downstream logic consumes bytes via a valid pulse.
//  - Synchronises the async line, detects the start bit, samples mid-bit and reports framing errors.
//  - Outputs act_n, an active-low activity strobe that can drive LEDn directly.

---
 rtl/uart_rx_sampler.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Serial receive front end for an external UART on a spare pin.
//                Synchronises the asynchronous line, detects the start bit,
//                samples every bit at its centre, delivers each good byte with
//                a one-cycle valid pulse and flags bad frames. It also drives
//                an active-low activity strobe that can feed an LED directly.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    INTERNAL_OSC  in   1  sole clock (internal oscillator, ~2.08 MHz)
//    RST           in   1  asynchronous active-high reset
//    rx_pin        in   1  raw serial line, asynchronous, idles high
//    rx_data       out  8  last good byte (LSB first on the line); held
//    rx_valid      out  1  one-cycle pulse when rx_data updates
//    frame_err     out  1  one-cycle pulse on a bad stop bit (or parity)
//    act_n         out  1  low while the activity stretch counter is nonzero
//  Parameters
//    CLKS_PER_BIT  clock cycles per bit, 4..1023
//    ACT_HOLD      width of the activity stretch counter (2**ACT_HOLD cycles)
//  Configuration macro
//    UART_RX_PARITY_EN  defined   : 8E1 frames, even-parity bit checked
//                       undefined : 8N1 frames, no parity logic present
// ============================================================================
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 18,
  parameter int ACT_HOLD     = 16
) (
  input  logic       INTERNAL_OSC,
  input  logic       RST,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       act_n
);

  localparam int              c_CW        = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_FULL_LAST = c_CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge so that every
  // flop below leaves reset in the same cycle.
  // --------------------------------------------------------------------------
  logic rst_meta_q;
  logic rst_q;

  always_ff @(posedge INTERNAL_OSC or posedge RST) begin
    if (RST) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Line synchroniser. Flops reset to the idle (high) level so that reset
  // release never manufactures a falling edge on an idle line.
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic sync3_q;
  logic w_line;
  logic w_fall;

  always_ff @(posedge INTERNAL_OSC or posedge rst_q) begin
    if (rst_q) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign w_line = sync2_q;
  assign w_fall = sync3_q & ~sync2_q;

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_t          state_q;
  logic [c_CW-1:0] bit_cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shreg_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            frame_err_q;
  logic            w_full;
  logic            w_par_bad;

  assign w_full = (bit_cnt_q == c_FULL_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign w_par_bad = par_err_q;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge INTERNAL_OSC or posedge rst_q) begin
    if (rst_q) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      bit_cnt_q   <= bit_cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          bit_cnt_q <= '0;
          idx_q     <= '0;
`ifdef UART_RX_PARITY_EN
          par_err_q <= 1'b0;
`endif
          if (w_fall) begin
            state_q <= S_START;
          end
        end
        // Half a bit in: a line that is high again was only a glitch.
        S_START: begin
          if (bit_cnt_q == c_HALF_LAST) begin
            bit_cnt_q <= '0;
            state_q   <= w_line ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_full) begin
            bit_cnt_q      <= '0;
            shreg_q[idx_q] <= w_line;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit equals the XOR of the data bits.
        S_PARITY: begin
          if (w_full) begin
            bit_cnt_q <= '0;
            par_err_q <= w_line ^ (^shreg_q);
            state_q   <= S_STOP;
          end
        end
`endif
        // Returning to IDLE at mid stop bit leaves half a bit of margin to
        // catch an immediately following start edge.
        S_STOP: begin
          if (w_full) begin
            bit_cnt_q <= '0;
            if (w_line && !w_par_bad) begin
              rx_data_q  <= shreg_q;
              rx_valid_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= w_line ? S_IDLE : S_BREAK;
            end
          end
        end
        // Hold here while the line stays low so a break reports only once.
        S_BREAK: begin
          bit_cnt_q <= '0;
          if (w_line) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

  // --------------------------------------------------------------------------
  // Activity stretch: reload on every good byte, count down to zero.
  // --------------------------------------------------------------------------
  logic [ACT_HOLD-1:0] act_cnt_q;

  always_ff @(posedge INTERNAL_OSC or posedge rst_q) begin
    if (rst_q) begin
      act_cnt_q <= '0;
    end else if (rx_valid_q) begin
      act_cnt_q <= '1;
    end else if (act_cnt_q != '0) begin
      act_cnt_q <= act_cnt_q - 1'b1;
    end
  end

  assign act_n = (act_cnt_q == '0);

endmodule
`default_nettype wire
